// File: rtl/smol_stream_pkg.sv
// Shared stream defaults and helpers for the smol FIFO and the producer/consumer blocks built around it.
package smol_stream_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    // Ceiling log2, usable in parameter expressions; clog2(1) returns 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/smol_stream_fifo_mem.sv
// DEPTH x W register array for the stream FIFO: synchronous write, asynchronous read, contents not reset.
module smol_stream_fifo_mem
    import smol_stream_pkg::*;
#(
    parameter int W      = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/smol_stream_fifo.sv
// Valid/ready stream FIFO: pointers, occupancy and registered handshakes around smol_stream_fifo_mem.
// Optional last sideband enabled by defining SMOL_STREAM_FIFO_LAST_EN.
module smol_stream_fifo
    import smol_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_vld,
    output logic              s_rdy,
    input  logic [DATA_W-1:0] s_data,
`ifdef SMOL_STREAM_FIFO_LAST_EN
    input  logic              s_last,
    output logic              m_last,
`endif
    output logic              m_vld,
    input  logic              m_rdy,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   level
);

`ifdef SMOL_STREAM_FIFO_LAST_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_ptr_nxt;
    logic [ADDR_W:0] rd_ptr_nxt;
    logic [ADDR_W:0] level_nxt;
    logic            push;
    logic            pop;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;

    assign push = s_vld && s_rdy;
    assign pop  = m_vld && m_rdy;

    assign wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, pop};
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    // Handshakes are registered from next-state occupancy, so neither depends on the opposite port
    // in the same cycle, and s_rdy stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            s_rdy  <= 1'b0;
            m_vld  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            s_rdy  <= (level_nxt != FULL_LVL);
            m_vld  <= (level_nxt != '0);
        end
    end

    assign level = wr_ptr - rd_ptr;

`ifdef SMOL_STREAM_FIFO_LAST_EN
    assign wr_word = {s_last, s_data};
`else
    assign wr_word = s_data;
`endif

    smol_stream_fifo_mem #(
        .W      (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    // Storage is never reset; gate the head so the outputs read zero while the FIFO is empty.
    assign m_data = m_vld ? rd_word[DATA_W-1:0] : '0;
`ifdef SMOL_STREAM_FIFO_LAST_EN
    assign m_last = m_vld ? rd_word[DATA_W] : 1'b0;
`endif

endmodule

// File: tb/tb_smol_stream_fifo.sv
// Self-checking bench for smol_stream_fifo against a queue model; covers the last sideband when
// SMOL_STREAM_FIFO_LAST_EN is defined.
module tb_smol_stream_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic              s_vld;
    logic              s_rdy;
    logic [DATA_W-1:0] s_data;
    logic              s_last_drv;
    logic              m_vld;
    logic              m_rdy;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W:0]   level;
`ifdef SMOL_STREAM_FIFO_LAST_EN
    logic              m_last;
`endif

    smol_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_vld  (s_vld),
        .s_rdy  (s_rdy),
        .s_data (s_data),
`ifdef SMOL_STREAM_FIFO_LAST_EN
        .s_last (s_last_drv),
        .m_last (m_last),
`endif
        .m_vld  (m_vld),
        .m_rdy  (m_rdy),
        .m_data (m_data),
        .level  (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: FIFO contents as a queue of {last, data}; armed goes high at the first edge out of reset.
    logic [DATA_W:0] q [$];
    bit              armed = 0;
    int              pushes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, predict transfers, then update the model after
    // the rising edge.
    task automatic cycle();
        bit              exp_rdy;
        bit              do_push;
        bit              do_pop;
        logic [DATA_W:0] word;
        logic [DATA_W:0] head;
        @(negedge clk);
        exp_rdy = armed && (q.size() < DEPTH);
        head    = (q.size() > 0) ? q[0] : '0;
        chk("s_rdy", 64'(s_rdy), 64'(exp_rdy));
        chk("m_vld", 64'(m_vld), 64'(q.size() > 0));
        chk("level", 64'(level), 64'(q.size()));
        chk("m_data", 64'(m_data), 64'(head[DATA_W-1:0]));
`ifdef SMOL_STREAM_FIFO_LAST_EN
        chk("m_last", 64'(m_last), 64'(head[DATA_W]));
`endif
        do_push = s_vld && exp_rdy;
        do_pop  = m_rdy && (q.size() > 0);
`ifdef SMOL_STREAM_FIFO_LAST_EN
        word = {s_last_drv, s_data};
`else
        word = {1'b0, s_data};
`endif
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) begin
                q.push_back(word);
                pushes++;
            end
            armed = 1;
        end
    endtask

    function automatic logic last_for(input int n);
        return (n % 4) == 3;
    endfunction

    initial begin
        logic [DATA_W-1:0] val;

        rst_n      = 1'b0;
        s_vld      = 1'b0;
        s_data     = '0;
        s_last_drv = 1'b0;
        m_rdy      = 1'b0;

        for (int i = 0; i < 5; i++) cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_release_rdy", 64'(s_rdy), 64'(1));

        // Fill with the sink stalled: data advances only when a word is taken.
        val = 32'h1;
        for (int i = 0; i < 10; i++) begin
            s_vld      = 1'b1;
            s_data     = val;
            s_last_drv = last_for(pushes);
            cycle();
            if (q.size() > 0 && q[q.size()-1][DATA_W-1:0] == val) val = val + 1;
        end
        chk("fill_level", 64'(level), 64'(8));
        chk("fill_srdy", 64'(s_rdy), 64'(0));
        chk("fill_head", 64'(m_data), 64'(32'h1));

        s_vld = 1'b0;
        m_rdy = 1'b1;
        for (int i = 0; i < 9; i++) cycle();
        chk("drain_mvld", 64'(m_vld), 64'(0));
        chk("drain_level", 64'(level), 64'(0));

        // Streaming: both sides always ready, counter payload.
        s_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data     = 32'h1000 + 32'(i);
            s_last_drv = last_for(pushes);
            cycle();
        end
        chk("stream_level", 64'(level), 64'(1));

        // Random traffic with pointer wrap.
        for (int i = 0; i < 2000; i++) begin
            s_vld      = 1'($urandom_range(0, 1));
            m_rdy      = 1'($urandom_range(0, 1));
            s_data     = $urandom;
            s_last_drv = last_for(pushes);
            cycle();
        end

        // Fill partially, then reset mid-burst: level must drop at once, without a clock edge.
        m_rdy = 1'b0;
        s_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data     = $urandom;
            s_last_drv = last_for(pushes);
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", 64'(level), 64'(0));
        chk("async_rst_mvld", 64'(m_vld), 64'(0));
        chk("async_rst_srdy", 64'(s_rdy), 64'(0));
        q.delete();
        armed = 0;
        s_vld = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
        rst_n = 1'b1;
        m_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            s_vld      = 1'($urandom_range(0, 1));
            s_data     = $urandom;
            s_last_drv = last_for(pushes);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
